scanner_link_rx: RTL
====================

# scanner_link_rx

Receive-side endpoint of the scanner serial link. Oversamples the scanner's `serClk`/`serData` pair in the local `clk` domain and deserializes LSB-first 8-bit frames. It decodes the command bytes (2, 3, 4, 7) into single-cycle strobes. The data byte that follows a command 7 goes through a one-entry valid/ready holding register to the downstream buffer controller.

## Interface
Parameters:
- `IDLE_TIMEOUT`, 16: `clk` cycles without a detected `serClk` rising edge before a partial frame is aborted. Legal range 2..255.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `serClk` in 1: link bit clock from the scanner. Asynchronous to `clk`.
- `serData` in 1: link data from the scanner. Sampled on the `serClk` rising edge.
- `cmdReadyToTransfer` out 1: one-cycle pulse on decoded command 8'd2.
- `cmdStartScan` out 1: one-cycle pulse on decoded command 8'd3.
- `cmdFull` out 1: one-cycle pulse on decoded command 8'd4.
- `cmdUnknown` out 1: one-cycle pulse on any other completed command byte.
- `rxData` out 8: received data byte. Held until the next load.
- `rxValid` out 1: `rxData` holds an unconsumed byte.
- `rxReady` in 1: downstream accepts `rxData` when `rxValid && rxReady`.
- `overflow` out 1: sticky. Set when a data byte is dropped because the holding register was full. Cleared only by `rst`.
- `frameErr` out 1: one-cycle pulse on a timeout abort.
- `dataByteCount` out 8: number of data bytes loaded into `rxData`. Wraps 255→0.
- `inData` out 1: FSM state. 0 = S_CMD, 1 = S_DATA.

## Operation
- Synchronizer: `serClk` and `serData` each pass through a 2-FF synchronizer; all decisions use the second stage.
- Edge detect: cycle E is an edge cycle when the synchronized `serClk` is 1 and was 0 in the previous cycle.
- Arming after reset: edge detection stays disabled until synchronized `serClk` has been seen at 0 once. A `serClk` held high through reset therefore produces no false bit.
- Bit capture: in cycle E, `shift <= {syncData, shift[7:1]}` (LSB first) and `bitCnt` (3 bits) increments.
- Byte completion: the edge with `bitCnt == 7` completes a byte (the shift value including this bit). `bitCnt` wraps to 0.
- FSM, S_CMD, on a completed byte:
  - 2, 3 or 4: pulse the matching `cmd*` output.
  - 7: go to S_DATA. No strobe.
  - Any other value: pulse `cmdUnknown`.
  - Stay in S_CMD except on 7.
- FSM, S_DATA, on a completed byte: attempt a load into the holding register, then return to S_CMD.
- Load rule, evaluated at the completion edge:
  - If `rxValid && !rxReady`: drop the byte, set `overflow`, leave `dataByteCount` unchanged.
  - Otherwise: `rxData <= byte`, `rxValid <= 1`, `dataByteCount += 1`.
- Handshake: `rxValid` clears on any cycle with `rxValid && rxReady`, unless a load happens in the same cycle (the load wins and `rxValid` stays 1).
- Timeout counter:
  - Cleared on every edge cycle; otherwise increments, saturating at `IDLE_TIMEOUT`.
  - When it reaches `IDLE_TIMEOUT` and (`bitCnt != 0` or state is S_DATA): clear `bitCnt` and `shift`, force S_CMD, pulse `frameErr`. This fires once per idle period.
  - A timeout with `bitCnt == 0` in S_CMD is silent.
  - An edge in the same cycle the counter would reach `IDLE_TIMEOUT` takes priority: the bit is accepted and there is no abort.
- Reset mid-frame discards the partial byte. Every state element returns to its reset value and the arming requirement applies again.

## Timing
- Reset values: all outputs 0; `inData` = 0 (S_CMD); `shift`, `bitCnt`, timeout counter, synchronizers and arm flag all 0.
- Link requirement: `serClk` high ≥ 2 `clk` cycles and low ≥ 2 `clk` cycles; `serData` stable from 3 `clk` cycles before to 1 cycle after each `serClk` rise. Minimum bit period is 4 `clk` cycles.
- Latency from the raw `serClk` rise to edge cycle E: 2–3 `clk` cycles.
- Command strobes, `frameErr`, and `rxValid`/`rxData`/`dataByteCount` updates are all registered and appear in cycle E+1 (or timeout-cycle+1). Each strobe is exactly 1 cycle wide.
- `inData` changes in cycle E+1 after the completing edge.
- Back-to-back frames need no gap. A data byte may immediately follow command 7 with the minimum bit period.

## Test plan
- Reset with `serClk` held high, then release and drive frame 8'd3 → exactly one `cmdStartScan` pulse, no other strobes, `inData` stays 0.
- Frames 2, 4, 8'd9 at minimum bit period → `cmdReadyToTransfer`, `cmdFull`, `cmdUnknown` pulses in that order, each 1 cycle.
- Frame 7 then 8'hA5 with `rxReady` = 1 → `inData` = 1 between the frames; `rxValid` = 1 for 1 cycle with `rxData` = 8'hA5; `dataByteCount` = 1; `inData` back to 0.
- Two 7+data sequences (8'h11, 8'h22) with `rxReady` held 0 → `rxData` = 8'h11, `overflow` = 1, `dataByteCount` = 1. Raising `rxReady` then clears `rxValid`.
- Send 5 bits of a frame, then idle for `IDLE_TIMEOUT` cycles → one `frameErr` pulse. A following full frame 8'd2 decodes as `cmdReadyToTransfer`.
- 256 data sequences with `rxReady` = 1 → `dataByteCount` wraps to 0. Assert `rst` mid-frame → all outputs 0 and the next full frame decodes correctly.

Source files
------------

// File: rtl/scanner_link_rx.sv
// Receive endpoint of the scanner serial link: oversamples serClk/serData in the clk
// domain, deserializes LSB-first bytes, decodes commands and hands data bytes downstream.
module scanner_link_rx #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serClk,
    input  logic       serData,
    output logic       cmdReadyToTransfer,
    output logic       cmdStartScan,
    output logic       cmdFull,
    output logic       cmdUnknown,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       overflow,
    output logic       frameErr,
    output logic [7:0] dataByteCount,
    output logic       inData
);

    typedef enum logic {
        S_CMD  = 1'b0,
        S_DATA = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT      = 8'(IDLE_TIMEOUT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic [1:0] sync_fill;
    logic       prev_clk;
    logic       armed;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [7:0] idle_cnt;
    state_t     state;

    logic       sync_clk;
    logic       sync_data;
    logic       edge_det;
    logic       abort;
    logic [7:0] next_shift;

    assign sync_clk   = clk_sync[1];
    assign sync_data  = data_sync[1];
    assign edge_det   = armed && sync_clk && !prev_clk;
    assign next_shift = {sync_data, shift[7:1]};
    assign abort      = !edge_det && (idle_cnt == TIMEOUT_LAST)
                        && ((bit_cnt != 3'd0) || (state == S_DATA));
    assign inData     = (state == S_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync           <= '0;
            data_sync          <= '0;
            sync_fill          <= '0;
            prev_clk           <= 1'b0;
            armed              <= 1'b0;
            shift              <= '0;
            bit_cnt            <= '0;
            idle_cnt           <= '0;
            state              <= S_CMD;
            cmdReadyToTransfer <= 1'b0;
            cmdStartScan       <= 1'b0;
            cmdFull            <= 1'b0;
            cmdUnknown         <= 1'b0;
            rxData             <= '0;
            rxValid            <= 1'b0;
            overflow           <= 1'b0;
            frameErr           <= 1'b0;
            dataByteCount      <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], serClk};
            data_sync <= {data_sync[0], serData};
            sync_fill <= {sync_fill[0], 1'b1};
            prev_clk  <= sync_clk;
            // NOTE: the synchronizer holds its reset zeros for two cycles; only a low level
            // seen after it has filled with real samples may arm edge detection.
            armed     <= armed | (sync_fill[1] & ~sync_clk);

            cmdReadyToTransfer <= 1'b0;
            cmdStartScan       <= 1'b0;
            cmdFull            <= 1'b0;
            cmdUnknown         <= 1'b0;
            frameErr           <= 1'b0;

            // NOTE: a load further down assigns rxValid again; the last non-blocking
            // assignment wins, so a same-cycle load keeps rxValid high.
            if (rxValid && rxReady)
                rxValid <= 1'b0;

            if (edge_det) begin
                idle_cnt <= '0;
                shift    <= next_shift;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        S_CMD: begin
                            case (next_shift)
                                8'd2:    cmdReadyToTransfer <= 1'b1;
                                8'd3:    cmdStartScan       <= 1'b1;
                                8'd4:    cmdFull            <= 1'b1;
                                8'd7:    state              <= S_DATA;
                                default: cmdUnknown         <= 1'b1;
                            endcase
                        end
                        S_DATA: begin
                            state <= S_CMD;
                            if (rxValid && !rxReady) begin
                                overflow <= 1'b1;
                            end else begin
                                rxData        <= next_shift;
                                rxValid       <= 1'b1;
                                dataByteCount <= dataByteCount + 8'd1;
                            end
                        end
                        default: state <= S_CMD;
                    endcase
                end
            end else begin
                if (idle_cnt != TIMEOUT)
                    idle_cnt <= idle_cnt + 8'd1;
                // Fires only on the step into saturation, so once per idle period.
                if (abort) begin
                    bit_cnt  <= '0;
                    shift    <= '0;
                    state    <= S_CMD;
                    frameErr <= 1'b1;
                end
            end
        end
    end

endmodule
